// File: rtl/vga_fb_reader_pkg.sv
// Shared types and helpers for the scaling framebuffer reader.
package vga_fb_reader_pkg;

    localparam int CNT_W  = 10;
    localparam int ADDR_W = 15;
    localparam int PIX_W  = 12;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_t;

    function automatic logic in_span(input logic [CNT_W-1:0] pos, input int lo, input int len);
        return (int'(pos) >= lo) && (int'(pos) < lo + len);
    endfunction

endpackage

// File: rtl/vga_fb_reader_line_buf.sv
// Ping-pong line buffer: two source lines, one write port, one registered read port.
module line_buf
    import vga_fb_reader_pkg::*;
#(
    parameter int DEPTH = 160,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = PIX_W
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_col,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_sel,
    input  logic [AW-1:0] rd_col,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:1][0:DEPTH-1];

    // Write from the fetch side, synchronous read for the display side
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_sel][wr_col] <= wr_data;
        end
        rd_data <= mem[rd_sel][rd_col];
    end

endmodule

// File: rtl/vga_fb_reader.sv
// Reads the source framebuffer line by line and emits a 3x upscaled, centred image on the VGA raster.
module vga_fb_reader
    import vga_fb_reader_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int SRC_W    = 160,
    parameter int SRC_H    = 144,
    parameter int SCALE    = 3,
    parameter int H_OFF    = 80,
    parameter int V_OFF    = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  h_sync_cnt,
    input  logic [CNT_W-1:0]  v_sync_cnt,
    input  logic              hs_in,
    input  logic              vs_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [PIX_W-1:0]  mem_data,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              underrun
);

    localparam int COL_W = $clog2(SRC_W);
    localparam int CW    = $clog2(SRC_W + 1);
    localparam int ROW_W = $clog2(SRC_H + 1);
    localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [ADDR_W-1:0] SRC_W_A = ADDR_W'(SRC_W);
    localparam logic [CW-1:0]     LAST_COL = CW'(SRC_W - 1);

    logic h_in_win_s, v_in_win_s, line_start_s;
    logic [ROW_W-1:0] src_row_r, src_row_nx;
    logic [SUB_W-1:0] sub_r, sub_nx, psub_r, cur_psub_s;
    logic [CW-1:0]    pcol_r, cur_pcol_s, col_r;
    logic disp_sel_r, disp_sel_nx;
    logic fetch_start_s, fetch_first_s, fetch_sel_s;
    logic [ADDR_W-1:0] next_base_r, fetch_base_s, pend_base_r, tgt_base_s;
    logic pend_sel_r, tgt_sel_s, fill_sel_r;
    fetch_state_t state_r, state_nx;
    logic wr_en_s, restart_s;
    logic [PIX_W-1:0] rd_data_s;
    logic win_d_r, hs_d_r, vs_d_r;

    assign h_in_win_s   = in_span(h_sync_cnt, H_OFF, SRC_W * SCALE) && (int'(h_sync_cnt) < H_ACTIVE);
    assign v_in_win_s   = in_span(v_sync_cnt, V_OFF, SRC_H * SCALE) && (int'(v_sync_cnt) < V_ACTIVE);
    assign line_start_s = (h_sync_cnt == 10'd0);
    assign fetch_base_s = fetch_first_s ? 15'd0 : next_base_r;
    assign tgt_base_s   = fetch_start_s ? fetch_base_s : pend_base_r;
    assign tgt_sel_s    = fetch_start_s ? fetch_sel_s : pend_sel_r;

    // Line-start bookkeeping: which source row is shown and which one to fetch next
    always_comb begin
        src_row_nx    = src_row_r;
        sub_nx        = sub_r;
        disp_sel_nx   = disp_sel_r;
        fetch_start_s = 1'b0;
        fetch_first_s = 1'b0;
        fetch_sel_s   = 1'b0;
        if (line_start_s) begin
            if (int'(v_sync_cnt) == V_OFF - 1) begin
                fetch_start_s = 1'b1;
                fetch_first_s = 1'b1;
            end else if (int'(v_sync_cnt) == V_OFF) begin
                disp_sel_nx   = 1'b0;
                src_row_nx    = '0;
                sub_nx        = '0;
                fetch_start_s = 1'b1;
                fetch_sel_s   = 1'b1;
            end else if (v_in_win_s) begin
                if (int'(sub_r) < SCALE - 1) begin
                    sub_nx = sub_r + SUB_W'(1);
                end else begin
                    sub_nx        = '0;
                    src_row_nx    = src_row_r + ROW_W'(1);
                    disp_sel_nx   = ~disp_sel_r;
                    fetch_start_s = (int'(src_row_r) + 2 < SRC_H);
                    fetch_sel_s   = disp_sel_r;
                end
            end else begin
                fetch_start_s = 1'b0;
            end
        end else begin
            fetch_start_s = 1'b0;
        end
    end

    // Row tracking registers; the next row base advances by one source line per fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            src_row_r   <= '0;
            sub_r       <= '0;
            disp_sel_r  <= 1'b0;
            next_base_r <= 15'd0;
        end else begin
            src_row_r  <= src_row_nx;
            sub_r      <= sub_nx;
            disp_sel_r <= disp_sel_nx;
            if (fetch_start_s) begin
                next_base_r <= fetch_base_s + SRC_W_A;
            end
        end
    end

    // Fetch sequencing; a start while busy lets the in-flight read finish before restarting
    always_comb begin
        state_nx  = state_r;
        wr_en_s   = 1'b0;
        restart_s = 1'b0;
        case (state_r)
            FETCH_IDLE: begin
                if (fetch_start_s) begin
                    state_nx  = FETCH_REQ;
                    restart_s = 1'b1;
                end else begin
                    state_nx = FETCH_IDLE;
                end
            end
            FETCH_REQ: begin
                wr_en_s = mem_ack;
                if (fetch_start_s) begin
                    if (mem_ack) begin
                        restart_s = 1'b1;
                    end else begin
                        state_nx = FETCH_DRAIN;
                    end
                end else if (mem_ack && (col_r == LAST_COL)) begin
                    state_nx = FETCH_IDLE;
                end else begin
                    state_nx = FETCH_REQ;
                end
            end
            FETCH_DRAIN: begin
                if (mem_ack) begin
                    state_nx  = FETCH_REQ;
                    restart_s = 1'b1;
                end else begin
                    state_nx = FETCH_DRAIN;
                end
            end
            default: state_nx = FETCH_IDLE;
        endcase
    end

    // Fetch datapath: address only moves on an ack or when a new row is launched
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= FETCH_IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= 15'd0;
            col_r       <= '0;
            fill_sel_r  <= 1'b0;
            pend_base_r <= 15'd0;
            pend_sel_r  <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state_r <= state_nx;
            mem_req <= (state_nx != FETCH_IDLE);
            if (fetch_start_s) begin
                pend_base_r <= fetch_base_s;
                pend_sel_r  <= fetch_sel_s;
                if (state_r != FETCH_IDLE) begin
                    underrun <= 1'b1;
                end
            end
            if (restart_s) begin
                mem_addr   <= tgt_base_s;
                col_r      <= '0;
                fill_sel_r <= tgt_sel_s;
            end else if (wr_en_s && (state_nx == FETCH_REQ)) begin
                mem_addr <= mem_addr + 15'd1;
                col_r    <= col_r + CW'(1);
            end
        end
    end

    assign cur_pcol_s = (int'(h_sync_cnt) == H_OFF) ? '0 : pcol_r;
    assign cur_psub_s = (int'(h_sync_cnt) == H_OFF) ? '0 : psub_r;

    // Horizontal replication counters, restarted at the first window column
    always_ff @(posedge clk) begin
        if (rst) begin
            pcol_r <= '0;
            psub_r <= '0;
        end else if (h_in_win_s) begin
            if (int'(cur_psub_s) == SCALE - 1) begin
                psub_r <= '0;
                pcol_r <= cur_pcol_s + CW'(1);
            end else begin
                psub_r <= cur_psub_s + SUB_W'(1);
                pcol_r <= cur_pcol_s;
            end
        end
    end

    line_buf #(.DEPTH(SRC_W), .AW(COL_W), .DW(PIX_W)) u_line_buf (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_sel  (fill_sel_r),
        .wr_col  (col_r[COL_W-1:0]),
        .wr_data (mem_data),
        .rd_sel  (disp_sel_r),
        .rd_col  (cur_pcol_s[COL_W-1:0]),
        .rd_data (rd_data_s)
    );

    // Two-stage display pipeline with sync delayed to match
    always_ff @(posedge clk) begin
        if (rst) begin
            win_d_r <= 1'b0;
            hs_d_r  <= 1'b0;
            vs_d_r  <= 1'b0;
            vga_hs  <= 1'b0;
            vga_vs  <= 1'b0;
            vga_r   <= 4'd0;
            vga_g   <= 4'd0;
            vga_b   <= 4'd0;
        end else begin
            win_d_r <= h_in_win_s && v_in_win_s;
            hs_d_r  <= hs_in;
            vs_d_r  <= vs_in;
            vga_hs  <= hs_d_r;
            vga_vs  <= vs_d_r;
            vga_r   <= win_d_r ? rd_data_s[11:8] : 4'd0;
            vga_g   <= win_d_r ? rd_data_s[7:4]  : 4'd0;
            vga_b   <= win_d_r ? rd_data_s[3:0]  : 4'd0;
        end
    end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Randomized bench for vga_fb_reader on a shrunken raster, checked against a behavioural framebuffer model.
module tb_vga_fb_reader;

    localparam int H_ACTIVE = 64;
    localparam int V_ACTIVE = 24;
    localparam int SRC_W    = 16;
    localparam int SRC_H    = 6;
    localparam int SCALE    = 3;
    localparam int H_OFF    = 8;
    localparam int V_OFF    = 3;
    localparam int H_TOTAL  = 96;
    localparam int V_TOTAL  = 28;

    logic clk = 1'b0;
    logic rst;
    logic [9:0] h_sync_cnt, v_sync_cnt;
    logic hs_in, vs_in, mem_req, mem_ack;
    logic [14:0] mem_addr;
    logic [11:0] mem_data;
    logic [3:0] vga_r, vga_g, vga_b;
    logic vga_hs, vga_vs, underrun;

    int total = 0;
    int bad = 0;
    int data_mode = 0;
    int delay_mode = 0;
    int seed = 0;
    bit chk = 1'b0;
    bit ur_seen = 1'b0;
    int sweep_cnt = 0;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic hs;
        logic vs;
        logic rst;
        logic chk;
    } smp_t;
    smp_t hist [3];

    always #5 clk = ~clk;

    vga_fb_reader #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .SRC_W(SRC_W), .SRC_H(SRC_H),
        .SCALE(SCALE), .H_OFF(H_OFF), .V_OFF(V_OFF)
    ) dut (
        .clk(clk), .rst(rst), .h_sync_cnt(h_sync_cnt), .v_sync_cnt(v_sync_cnt),
        .hs_in(hs_in), .vs_in(vs_in), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .vga_r(vga_r), .vga_g(vga_g),
        .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs), .underrun(underrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] fb_value(input int addr);
        logic [31:0] t;
        case (data_mode)
            0: t = 32'h0000_0F00;
            1: t = addr;
            default: t = addr * 37 + seed;
        endcase
        return t[11:0];
    endfunction

    function automatic logic [11:0] model_pixel(input int h, input int v);
        if (h >= H_OFF && h < H_OFF + SRC_W * SCALE && v >= V_OFF && v < V_OFF + SRC_H * SCALE)
            return fb_value(((v - V_OFF) / SCALE) * SRC_W + (h - H_OFF) / SCALE);
        return 12'd0;
    endfunction

    // Memory responder with configurable ack latency plus request-protocol checks
    initial begin
        int wait_cnt, cur_delay, sweep_next;
        bit req_q, ack_q, rst_q, sweep_on;
        logic [14:0] addr_q;
        mem_ack = 1'b0; mem_data = 12'd0;
        wait_cnt = 0; cur_delay = 0; sweep_next = 0; sweep_on = 1'b0;
        req_q = 1'b0; ack_q = 1'b0; rst_q = 1'b1; addr_q = 15'd0;
        forever begin
            @(negedge clk);
            if (req_q && !ack_q && !rst_q) begin
                check("req_held", mem_req, 1);
                check("addr_stable", mem_addr, addr_q);
            end
            if (rst || !mem_req) begin
                mem_ack = 1'b0;
                wait_cnt = 0;
            end else if (wait_cnt >= cur_delay) begin
                mem_ack = 1'b1;
                mem_data = fb_value(int'(mem_addr));
                if (data_mode == 1) begin
                    if (mem_addr == 15'd32) begin
                        sweep_on = 1'b1; sweep_next = 33;
                    end else if (sweep_on) begin
                        check("addr_sweep", mem_addr, sweep_next);
                        sweep_cnt++;
                        sweep_next++;
                        if (sweep_next == 48) sweep_on = 1'b0;
                    end
                end
                wait_cnt = 0;
                cur_delay = (delay_mode == 0) ? 0 : (delay_mode == 1) ? int'($urandom_range(0, 4)) : 20;
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
            req_q = mem_req; ack_q = mem_ack; rst_q = rst; addr_q = mem_addr;
        end
    end

    // Output comparison against the model, two cycles behind the raster inputs
    initial begin
        logic [11:0] rgb;
        for (int i = 0; i < 3; i++) hist[i] = '{h: 10'd0, v: 10'd0, hs: 1'b0, vs: 1'b0, rst: 1'b1, chk: 1'b0};
        forever begin
            @(negedge clk);
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = '{h: h_sync_cnt, v: v_sync_cnt, hs: hs_in, vs: vs_in, rst: rst, chk: chk};
            rgb = {vga_r, vga_g, vga_b};
            if (hist[1].rst) begin
                check("rst_req", mem_req, 0);
                check("rst_rgb", rgb, 0);
            end else if (!hist[2].rst) begin
                check("hs_align", vga_hs, hist[2].hs);
                check("vs_align", vga_vs, hist[2].vs);
                if (hist[2].chk) begin
                    check("pixel", rgb, model_pixel(int'(hist[2].h), int'(hist[2].v)));
                    if (data_mode == 0 && int'(hist[2].v) == V_OFF) begin
                        if (int'(hist[2].h) == H_OFF) check("pin_first_px", rgb, 32'h0000_0F00);
                        if (int'(hist[2].h) == H_OFF - 1) check("pin_left_edge", rgb, 0);
                        if (int'(hist[2].h) == H_OFF + SRC_W * SCALE) check("pin_right_edge", rgb, 0);
                    end
                    if (data_mode == 1 && hist[2].v >= 10'd9 && hist[2].v <= 10'd11
                        && hist[2].h >= 10'd23 && hist[2].h <= 10'd25)
                        check("pin_px_5_2", rgb, 32'h0000_0025);
                end
            end
            if (delay_mode != 2) begin
                check("underrun_clear", underrun, 0);
            end else begin
                if (ur_seen) check("underrun_sticky", underrun, 1);
                if (underrun === 1'b1) ur_seen = 1'b1;
            end
        end
    end

    // Raster driver: six frames with changing data, ack latency and a mid-fetch reset
    initial begin
        bit pix_ok;
        rst = 1'b1; h_sync_cnt = 10'd0; v_sync_cnt = 10'd0; hs_in = 1'b0; vs_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req", mem_req, 0);
        check("reset_addr", mem_addr, 0);
        check("reset_rgb", {vga_r, vga_g, vga_b}, 0);
        check("reset_hs", vga_hs, 0);
        check("reset_vs", vga_vs, 0);
        check("reset_underrun", underrun, 0);
        for (int f = 0; f < 6; f++) begin
            data_mode  = (f == 0) ? 0 : (f == 1) ? 1 : 2;
            delay_mode = (f < 2) ? 0 : (f < 5) ? 1 : 2;
            if (f == 2) seed = int'($urandom_range(0, 4095));
            pix_ok = (f != 5);
            for (int vv = 0; vv < V_TOTAL; vv++) begin
                for (int hh = 0; hh < H_TOTAL; hh++) begin
                    h_sync_cnt = 10'(hh);
                    v_sync_cnt = 10'(vv);
                    hs_in = 1'($urandom);
                    vs_in = 1'($urandom);
                    rst = 1'b0;
                    if (f == 3 && vv == 9 && hh == 10) begin
                        check("req_before_rst", mem_req, 1);
                        rst = 1'b1;
                        pix_ok = 1'b0;
                    end
                    chk = pix_ok;
                    @(posedge clk);
                    #1;
                end
            end
        end
        chk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("underrun_final", underrun, 1);
        check("underrun_seen", ur_seen, 1);
        check("sweep_len", sweep_cnt, 15);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
